// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addressing, write masks, reset values,
// Status/Cause field positions and ExcCode constants.
package cp0_pkg;

    typedef enum logic [3:0] {
        CP0_BADVADDR,
        CP0_COUNT,
        CP0_COMPARE,
        CP0_STATUS,
        CP0_CAUSE,
        CP0_EPC,
        CP0_PRID,
        CP0_CONFIG,
        CP0_CONFIG1,
        CP0_ERROREPC,
        CP0_NONE
    } cp0_reg_e;

    localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};
    localparam logic [7:0] ADDR_PRID     = {5'd15, 3'd0};
    localparam logic [7:0] ADDR_CONFIG   = {5'd16, 3'd0};
    localparam logic [7:0] ADDR_CONFIG1  = {5'd16, 3'd1};
    localparam logic [7:0] ADDR_ERROREPC = {5'd30, 3'd0};

    localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK   = 32'h0000_0300;
    localparam logic [31:0] STATUS_RESET  = 32'h0040_0000;
    localparam logic [31:0] CONFIG1_VALUE = 32'h0000_0000;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_HWIP_LO = 10;
    localparam int CA_IP7    = 15;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    function automatic cp0_reg_e cp0_decode(input logic [4:0] rd, input logic [2:0] sel);
        cp0_reg_e r;
        r = CP0_NONE;
        case ({rd, sel})
            ADDR_BADVADDR: r = CP0_BADVADDR;
            ADDR_COUNT:    r = CP0_COUNT;
            ADDR_COMPARE:  r = CP0_COMPARE;
            ADDR_STATUS:   r = CP0_STATUS;
            ADDR_CAUSE:    r = CP0_CAUSE;
            ADDR_EPC:      r = CP0_EPC;
            ADDR_PRID:     r = CP0_PRID;
            ADDR_CONFIG:   r = CP0_CONFIG;
            ADDR_CONFIG1:  r = CP0_CONFIG1;
            ADDR_ERROREPC: r = CP0_ERROREPC;
            default:       r = CP0_NONE;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] cp0_merge(input logic [31:0] old_v,
                                              input logic [31:0] wdata,
                                              input logic [31:0] mask);
        return (old_v & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count plus a one-cycle TI set strobe when
// Count reaches Compare right after an increment.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic        count_wr_i,
    input  logic        compare_wr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic        ti_set_o
);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             inc_q, inc_d;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        count_d   = tick ? count_q + 32'd1 : count_q;
        inc_d     = tick;
        compare_d = compare_wr_i ? wdata_i : compare_q;
        // A software write to Count overrides a coincident tick and restarts the prescaler.
        if (count_wr_i) begin
            count_d = wdata_i;
            div_d   = '0;
            inc_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            inc_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            inc_q     <= inc_d;
        end
    end

    assign count_o  = count_q;
    assign ti_set_o = inc_q & (count_q == compare_q) & ~compare_wr_i;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MFC0/MTC0 access, exception entry/ERET bookkeeping,
// hardware interrupt sampling and the registered interrupt request.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT   = 5,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VALUE = 32'h8000_0000
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_i,
    input  logic                  acc_valid_i,
    input  logic                  acc_write_i,
    input  logic [4:0]            acc_rd_i,
    input  logic [2:0]            acc_sel_i,
    input  logic [31:0]           acc_wdata_i,
    output logic [31:0]           acc_rdata_o,
    output logic                  acc_invalid_o,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic                  exc_badva_valid_i,
    input  logic [31:0]           exc_badva_i,
    input  logic                  eret_valid_i,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    output logic [31:0]           epc_o,
    output logic                  int_pending_o,
    output logic                  status_exl_o
);
    cp0_reg_e acc_reg;
    logic     mtc0;
    logic     wr_status, wr_cause, wr_epc, wr_errorepc, wr_count, wr_compare;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badva_q, badva_d;
    logic [31:0] errorepc_q, errorepc_d;
    logic [NUM_HW_INT-1:0] sync_q;
    logic [31:0] rdata_q, rd_mux;
    logic        invalid_q;
    logic        int_q, int_d;
    logic [31:0] count;
    logic        ti_set;

    assign acc_reg = cp0_decode(acc_rd_i, acc_sel_i);
    // Exception and ERET take the cycle; a coincident MTC0 is dropped entirely.
    assign mtc0        = acc_valid_i & acc_write_i & ~exc_valid_i & ~eret_valid_i;
    assign wr_status   = mtc0 && (acc_reg == CP0_STATUS);
    assign wr_cause    = mtc0 && (acc_reg == CP0_CAUSE);
    assign wr_epc      = mtc0 && (acc_reg == CP0_EPC);
    assign wr_errorepc = mtc0 && (acc_reg == CP0_ERROREPC);
    assign wr_count    = mtc0 && (acc_reg == CP0_COUNT);
    assign wr_compare  = mtc0 && (acc_reg == CP0_COMPARE);

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk_sys_i    (clk_sys_i),
        .rst_i        (rst_i),
        .count_wr_i   (wr_count),
        .compare_wr_i (wr_compare),
        .wdata_i      (acc_wdata_i),
        .count_o      (count),
        .ti_set_o     (ti_set)
    );

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badva_d    = badva_q;
        errorepc_d = errorepc_q;
        if (wr_status)   status_d   = cp0_merge(status_q, acc_wdata_i, STATUS_WMASK);
        if (wr_cause)    cause_d    = cp0_merge(cause_q, acc_wdata_i, CAUSE_WMASK);
        if (wr_epc)      epc_d      = acc_wdata_i;
        if (wr_errorepc) errorepc_d = acc_wdata_i;
        // The hardware IP bits act as the second synchroniser stage.
        cause_d[CA_HWIP_LO +: NUM_HW_INT] = sync_q;
        if (wr_compare) begin
            cause_d[CA_TI]  = 1'b0;
            cause_d[CA_IP7] = 1'b0;
        end else if (ti_set) begin
            cause_d[CA_TI]  = 1'b1;
            cause_d[CA_IP7] = 1'b1;
        end
        if (exc_valid_i) begin
            cause_d[CA_EXC_LO +: 5] = exc_code_i;
            if (!status_q[ST_EXL]) begin
                epc_d          = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                cause_d[CA_BD] = exc_bd_i;
            end
            status_d[ST_EXL] = 1'b1;
            if (exc_badva_valid_i) badva_d = exc_badva_i;
        end else if (eret_valid_i) begin
            status_d[ST_EXL] = 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (acc_reg)
            CP0_BADVADDR: rd_mux = badva_q;
            CP0_COUNT:    rd_mux = count;
            CP0_COMPARE:  rd_mux = u_timer.compare_q;
            CP0_STATUS:   rd_mux = status_q;
            CP0_CAUSE:    rd_mux = cause_q;
            CP0_EPC:      rd_mux = epc_q;
            CP0_PRID:     rd_mux = PRID_VALUE;
            CP0_CONFIG:   rd_mux = CONFIG_VALUE;
            CP0_CONFIG1:  rd_mux = CONFIG1_VALUE;
            CP0_ERROREPC: rd_mux = errorepc_q;
            default:      rd_mux = '0;
        endcase
    end

    assign int_d = status_q[ST_IE] & ~status_q[ST_EXL]
                 & |(cause_q[CA_IP_LO +: 8] & status_q[ST_IM_LO +: 8]);

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            badva_q    <= '0;
            errorepc_q <= '0;
            sync_q     <= '0;
            rdata_q    <= '0;
            invalid_q  <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badva_q    <= badva_d;
            errorepc_q <= errorepc_d;
            sync_q     <= hw_int_i;
            int_q      <= int_d;
            if (acc_valid_i) begin
                invalid_q <= (acc_reg == CP0_NONE);
                if (!acc_write_i) rdata_q <= rd_mux;
            end
        end
    end

    assign acc_rdata_o   = rdata_q;
    assign acc_invalid_o = invalid_q;
    assign epc_o         = epc_q;
    assign int_pending_o = int_q;
    assign status_exl_o  = status_q[ST_EXL];

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed scoreboard bench for cp0_regfile: stimulus queues expected values,
// a negedge monitor pops and compares them as the DUT presents results.
module tb_cp0_regfile;
    logic        clk;
    logic        rst;
    logic        acc_valid, acc_write;
    logic [4:0]  acc_rd;
    logic [2:0]  acc_sel;
    logic [31:0] acc_wdata;
    logic [31:0] acc_rdata;
    logic        acc_invalid;
    logic        exc_valid, exc_bd, exc_badva_valid, eret_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_badva;
    logic [4:0]  hw_int;
    logic [31:0] epc;
    logic        int_pending, status_exl;

    localparam int P_INT = 0, P_EPC = 1, P_EXL = 2, P_INV = 3, P_RDATA = 4;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        inv;
    } rd_exp_t;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] data;
    } pr_exp_t;

    rd_exp_t rd_q[$];
    pr_exp_t pr_q[$];
    int      n_vec;
    int      n_miss;
    logic    rd_issued;
    rd_exp_t mon_rd;
    pr_exp_t mon_pr;
    logic [31:0] mon_act;

    cp0_regfile dut (
        .clk_sys_i         (clk),
        .rst_i             (rst),
        .acc_valid_i       (acc_valid),
        .acc_write_i       (acc_write),
        .acc_rd_i          (acc_rd),
        .acc_sel_i         (acc_sel),
        .acc_wdata_i       (acc_wdata),
        .acc_rdata_o       (acc_rdata),
        .acc_invalid_o     (acc_invalid),
        .exc_valid_i       (exc_valid),
        .exc_code_i        (exc_code),
        .exc_pc_i          (exc_pc),
        .exc_bd_i          (exc_bd),
        .exc_badva_valid_i (exc_badva_valid),
        .exc_badva_i       (exc_badva),
        .eret_valid_i      (eret_valid),
        .hw_int_i          (hw_int),
        .epc_o             (epc),
        .int_pending_o     (int_pending),
        .status_exl_o      (status_exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) rd_issued <= 1'b0;
        else     rd_issued <= acc_valid & ~acc_write;
    end

    always @(negedge clk) begin
        if (rd_issued) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_read: got %h/%b, nothing expected", acc_rdata, acc_invalid);
            end else begin
                mon_rd = rd_q.pop_front();
                if (acc_rdata !== mon_rd.data || acc_invalid !== mon_rd.inv) begin
                    n_miss++;
                    $display("FAIL %s: got rdata %h invalid %b, want rdata %h invalid %b",
                             mon_rd.name, acc_rdata, acc_invalid, mon_rd.data, mon_rd.inv);
                end
            end
        end
        while (pr_q.size() > 0) begin
            mon_pr = pr_q.pop_front();
            case (mon_pr.kind)
                P_INT:   mon_act = {31'd0, int_pending};
                P_EPC:   mon_act = epc;
                P_EXL:   mon_act = {31'd0, status_exl};
                P_INV:   mon_act = {31'd0, acc_invalid};
                default: mon_act = acc_rdata;
            endcase
            n_vec++;
            if (mon_act !== mon_pr.data) begin
                n_miss++;
                $display("FAIL %s: got %h, want %h", mon_pr.name, mon_act, mon_pr.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string nm, input int kind, input logic [31:0] exp);
        pr_exp_t p;
        p.name = nm;
        p.kind = kind;
        p.data = exp;
        pr_q.push_back(p);
    endtask

    task automatic mfc0(input string nm, input logic [4:0] rd, input logic [2:0] sel,
                        input logic [31:0] exp, input logic inv);
        rd_exp_t r;
        r.name = nm;
        r.data = exp;
        r.inv  = inv;
        rd_q.push_back(r);
        acc_valid = 1'b1;
        acc_write = 1'b0;
        acc_rd    = rd;
        acc_sel   = sel;
        step();
        acc_valid = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] wd);
        acc_valid = 1'b1;
        acc_write = 1'b1;
        acc_rd    = rd;
        acc_sel   = sel;
        acc_wdata = wd;
        step();
        acc_valid = 1'b0;
        acc_write = 1'b0;
    endtask

    task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                             input logic bva_v, input logic [31:0] bva);
        exc_valid       = 1'b1;
        exc_code        = code;
        exc_pc          = pc;
        exc_bd          = bd;
        exc_badva_valid = bva_v;
        exc_badva       = bva;
        step();
        exc_valid       = 1'b0;
        exc_badva_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_miss = 0;
        rst = 1'b1;
        acc_valid = 0; acc_write = 0; acc_rd = 0; acc_sel = 0; acc_wdata = 0;
        exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_badva_valid = 0; exc_badva = 0;
        eret_valid = 0; hw_int = 0;
        repeat (3) step();
        rst = 1'b0;
        probe("rst_int_pending", P_INT, 32'd0);
        probe("rst_epc", P_EPC, 32'd0);
        probe("rst_exl", P_EXL, 32'd0);
        probe("rst_rdata", P_RDATA, 32'd0);
        probe("rst_invalid", P_INV, 32'd0);

        mfc0("status_reset", 5'd12, 3'd0, 32'h0040_0000, 1'b0);
        mfc0("prid_reset",   5'd15, 3'd0, 32'h0000_4220, 1'b0);
        mfc0("config_reset", 5'd16, 3'd0, 32'h8000_0000, 1'b0);
        mfc0("config1_reset", 5'd16, 3'd1, 32'h0000_0000, 1'b0);

        mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
        probe("exl_from_mtc0", P_EXL, 32'd1);
        mfc0("status_wmask", 5'd12, 3'd0, 32'h0040_FF03, 1'b0);
        mtc0(5'd15, 3'd0, 32'h0);
        mfc0("prid_readonly", 5'd15, 3'd0, 32'h0000_4220, 1'b0);
        mtc0(5'd12, 3'd0, 32'h0000_8001);
        mfc0("status_im7_ie", 5'd12, 3'd0, 32'h0040_8001, 1'b0);

        // Count=5 lands on edge 10 after the Count write; TI on 11, int_pending on 12.
        mtc0(5'd11, 3'd0, 32'd5);
        mtc0(5'd9, 3'd0, 32'd0);
        repeat (11) step();
        probe("timer_int_not_yet", P_INT, 32'd0);
        step();
        probe("timer_int_rise", P_INT, 32'd1);
        mfc0("cause_ti", 5'd13, 3'd0, 32'h4000_8000, 1'b0);
        mfc0("count_value", 5'd9, 3'd0, 32'd6, 1'b0);
        mtc0(5'd11, 3'd0, 32'd5);
        probe("int_after_cmp_wr", P_INT, 32'd1);
        step();
        probe("int_cleared", P_INT, 32'd0);
        mfc0("cause_ti_cleared", 5'd13, 3'd0, 32'h0000_0000, 1'b0);

        raise_exc(5'd4, 32'hBFC0_0104, 1'b1, 1'b1, 32'h0000_1001);
        probe("exc1_epc", P_EPC, 32'hBFC0_0100);
        probe("exc1_exl", P_EXL, 32'd1);
        mfc0("exc1_cause", 5'd13, 3'd0, 32'h8000_0010, 1'b0);
        mfc0("exc1_badva", 5'd8, 3'd0, 32'h0000_1001, 1'b0);
        raise_exc(5'd8, 32'h8000_0180, 1'b0, 1'b0, 32'h0000_FFFF);
        probe("exc2_epc_kept", P_EPC, 32'hBFC0_0100);
        mfc0("exc2_cause", 5'd13, 3'd0, 32'h8000_0020, 1'b0);
        mfc0("exc2_badva_kept", 5'd8, 3'd0, 32'h0000_1001, 1'b0);
        eret_valid = 1'b1;
        step();
        eret_valid = 1'b0;
        probe("eret_exl", P_EXL, 32'd0);

        exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h8000_0200; exc_bd = 1'b0;
        eret_valid = 1'b1;
        acc_valid = 1'b1; acc_write = 1'b1; acc_rd = 5'd14; acc_sel = 3'd0; acc_wdata = 32'h0000_1234;
        step();
        exc_valid = 1'b0; eret_valid = 1'b0; acc_valid = 1'b0; acc_write = 1'b0;
        probe("prio_epc", P_EPC, 32'h8000_0200);
        probe("prio_exl", P_EXL, 32'd1);
        mfc0("prio_epc_read", 5'd14, 3'd0, 32'h8000_0200, 1'b0);
        eret_valid = 1'b1;
        step();
        eret_valid = 1'b0;
        probe("eret2_exl", P_EXL, 32'd0);

        mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
        mfc0("cause_wmask", 5'd13, 3'd0, 32'h0000_0330, 1'b0);
        mtc0(5'd14, 3'd0, 32'h0000_1234);
        probe("epc_mtc0", P_EPC, 32'h0000_1234);
        mfc0("epc_read", 5'd14, 3'd0, 32'h0000_1234, 1'b0);
        mtc0(5'd30, 3'd0, 32'hCAFE_F00D);
        mfc0("errorepc_read", 5'd30, 3'd0, 32'hCAFE_F00D, 1'b0);
        mfc0("unknown_read", 5'd7, 3'd0, 32'h0, 1'b1);
        mtc0(5'd7, 3'd0, 32'h0000_DEAD);
        probe("unknown_write_inv", P_INV, 32'd1);
        mfc0("status_after_eret", 5'd12, 3'd0, 32'h0040_8001, 1'b0);

        // One-cycle hw_int[0] pulse: int_pending high exactly 3 cycles later, for one cycle.
        mtc0(5'd12, 3'd0, 32'h0000_0401);
        hw_int = 5'b00001;
        step();
        hw_int = 5'b00000;
        probe("hw_int_c1", P_INT, 32'd0);
        step();
        probe("hw_int_c2", P_INT, 32'd0);
        step();
        probe("hw_int_c3", P_INT, 32'd1);
        step();
        probe("hw_int_c4", P_INT, 32'd0);

        step();
        rst = 1'b1;
        #1;
        probe("midrst_epc", P_EPC, 32'd0);
        probe("midrst_exl", P_EXL, 32'd0);
        step();
        rst = 1'b0;
        mfc0("midrst_count", 5'd9, 3'd0, 32'd0, 1'b0);
        mfc0("midrst_cause", 5'd13, 3'd0, 32'd0, 1'b0);
        mfc0("midrst_status", 5'd12, 3'd0, 32'h0040_0000, 1'b0);

        repeat (3) step();
        if (rd_q.size() != 0 || pr_q.size() != 0) begin
            n_miss += rd_q.size() + pr_q.size();
            $display("FAIL leftover_expectations: got %0d unchecked, want 0", rd_q.size() + pr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
